// File: rtl/uart_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_reg_bridge
// Brief   : Parses fixed-length R/W byte frames into 16-bit register accesses.
// Rev     : 1.0  initial release
// ============================================================================
module uart_reg_bridge #(
  parameter int unsigned P_TIMEOUT_CYC = 1000000,
  parameter int unsigned P_BUS_TIMEOUT = 255,
  parameter logic [15:0] P_RD_ERR_DATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  output logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [7:0]  wr_data,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  input  logic        reg_ack,
  output logic        busy,
  output logic        frame_err
);

  localparam int c_to_w  = $clog2(P_TIMEOUT_CYC + 1);
  localparam int c_bus_w = $clog2(P_BUS_TIMEOUT + 1);
  localparam logic [c_to_w-1:0]  c_to_max  = c_to_w'(P_TIMEOUT_CYC);
  localparam logic [c_bus_w-1:0] c_bus_max = c_bus_w'(P_BUS_TIMEOUT);
  localparam logic [7:0] c_cmd_wr  = 8'h57;
  localparam logic [7:0] c_cmd_rd  = 8'h52;
  localparam logic [7:0] c_rsp_ok  = 8'h4B;
  localparam logic [7:0] c_rsp_to  = 8'h21;
  localparam logic [7:0] c_rsp_bad = 8'h3F;

  localparam logic [2:0] S_CMD  = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DHI  = 3'd2;
  localparam logic [2:0] S_DLO  = 3'd3;
  localparam logic [2:0] S_BUS  = 3'd4;
  localparam logic [2:0] S_TX0  = 3'd5;
  localparam logic [2:0] S_TX1  = 3'd6;

  logic [2:0]         r_state, w_state_nxt;
  logic               r_rd_ack, r_is_rd, r_bus_on, r_wr_req, r_frame_err;
  logic [7:0]         r_byte, r_reg_addr, r_wr_data, r_tx_hi, r_tx_lo;
  logic [15:0]        r_reg_wdata;
  logic [c_to_w-1:0]  r_to_cnt;
  logic [c_bus_w-1:0] r_bus_cnt;
  logic [1:0]         r_gap;

  logic w_rx_state, w_rx_take, w_rx_done, w_to_wait, w_to_exp;
  logic w_bus_done, w_tx_state, w_tx_start, w_tx_done, w_cmd_ok;

  // A byte is consumed only when rd_req falls; expiry blocks acceptance so
  // a byte arriving in that cycle is picked up as a fresh command.
  assign w_rx_state = (r_state == S_CMD) || (r_state == S_ADDR) ||
                      (r_state == S_DHI) || (r_state == S_DLO);
  assign w_to_wait  = w_rx_state && (r_state != S_CMD) && !r_rd_ack;
  assign w_to_exp   = w_to_wait && (r_to_cnt == c_to_max);
  assign w_rx_take  = w_rx_state && !r_rd_ack && rd_req && !w_to_exp;
  assign w_rx_done  = w_rx_state && r_rd_ack && !rd_req;
  assign w_cmd_ok   = (r_byte == c_cmd_wr) || (r_byte == c_cmd_rd);
  assign w_bus_done = (r_state == S_BUS) && r_bus_on &&
                      (reg_ack || (r_bus_cnt == c_bus_max));
  assign w_tx_state = (r_state == S_TX0) || (r_state == S_TX1);
  assign w_tx_start = w_tx_state && !r_wr_req && (r_gap == 2'd2);
  assign w_tx_done  = w_tx_state && r_wr_req && wr_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_CMD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CMD:   if (w_rx_done) w_state_nxt = w_cmd_ok ? S_ADDR : S_TX0;
      S_ADDR:  if (w_to_exp) w_state_nxt = S_CMD;
               else if (w_rx_done) w_state_nxt = r_is_rd ? S_BUS : S_DHI;
      S_DHI:   if (w_to_exp) w_state_nxt = S_CMD;
               else if (w_rx_done) w_state_nxt = S_DLO;
      S_DLO:   if (w_to_exp) w_state_nxt = S_CMD;
               else if (w_rx_done) w_state_nxt = S_BUS;
      S_BUS:   if (w_bus_done) w_state_nxt = S_TX0;
      S_TX0:   if (w_tx_done) w_state_nxt = r_is_rd ? S_TX1 : S_CMD;
      S_TX1:   if (w_tx_done) w_state_nxt = S_CMD;
      default: w_state_nxt = S_CMD;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_CMD);
    reg_wr    = (r_state == S_BUS) && r_bus_on && !r_is_rd;
    reg_rd    = (r_state == S_BUS) && r_bus_on && r_is_rd;
    rd_ack    = r_rd_ack;
    wr_req    = r_wr_req;
    wr_data   = r_wr_data;
    reg_addr  = r_reg_addr;
    reg_wdata = r_reg_wdata;
    frame_err = r_frame_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ack    <= 1'b0;
      r_byte      <= '0;
      r_is_rd     <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_to_cnt    <= '0;
      r_bus_cnt   <= '0;
      r_bus_on    <= 1'b0;
      r_tx_hi     <= '0;
      r_tx_lo     <= '0;
      r_wr_req    <= 1'b0;
      r_wr_data   <= '0;
      r_gap       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_to_exp;

      if (w_rx_take) begin
        r_rd_ack <= 1'b1;
        r_byte   <= rd_data;
      end else if (w_rx_done) begin
        r_rd_ack <= 1'b0;
      end

      if (!w_to_wait)              r_to_cnt <= '0;
      else if (r_to_cnt != c_to_max) r_to_cnt <= r_to_cnt + c_to_w'(1);

      if (w_rx_done) begin
        case (r_state)
          S_CMD: begin
            r_is_rd <= (r_byte == c_cmd_rd);
            if (!w_cmd_ok) begin
              r_frame_err <= 1'b1;
              r_tx_hi     <= c_rsp_bad;
            end
          end
          S_ADDR:  r_reg_addr        <= r_byte;
          S_DHI:   r_reg_wdata[15:8] <= r_byte;
          S_DLO:   r_reg_wdata[7:0]  <= r_byte;
          default: ;
        endcase
      end

      // Request goes out the cycle after S_BUS entry; counter spans the wait.
      if (r_state == S_BUS) begin
        if (r_bus_cnt != c_bus_max) r_bus_cnt <= r_bus_cnt + c_bus_w'(1);
        r_bus_on <= !w_bus_done;
      end else begin
        r_bus_cnt <= '0;
        r_bus_on  <= 1'b0;
      end

      if (w_bus_done) begin
        if (r_is_rd) {r_tx_hi, r_tx_lo} <= reg_ack ? reg_rdata : P_RD_ERR_DATA;
        else         r_tx_hi            <= reg_ack ? c_rsp_ok : c_rsp_to;
      end

      if (r_wr_req)            r_gap <= 2'd0;
      else if (r_gap != 2'd2)  r_gap <= r_gap + 2'd1;

      if (w_tx_start) begin
        r_wr_req  <= 1'b1;
        r_wr_data <= (r_state == S_TX0) ? r_tx_hi : r_tx_lo;
      end else if (w_tx_done) begin
        r_wr_req  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_reg_bridge
// Brief   : Frame-level reference model bench with host, adapter and bus agents.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_reg_bridge;

  localparam int TO_CYC = 100;
  localparam int BUS_TO = 16;

  logic        clk = 1'b0;
  logic        rst, rd_req, rd_ack, wr_req, wr_ack;
  logic [7:0]  rd_data, wr_data, reg_addr;
  logic [15:0] reg_wdata, reg_rdata;
  logic        reg_wr, reg_rd, reg_ack, busy, frame_err;

  uart_reg_bridge #(
    .P_TIMEOUT_CYC(TO_CYC),
    .P_BUS_TIMEOUT(BUS_TO),
    .P_RD_ERR_DATA(16'hDEAD)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_data(wr_data),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int bus_lat = 0;
  int n_wr_acc = 0, n_rd_acc = 0, n_ferr = 0, req_len = 0;
  int exp_nwr, exp_nrd, exp_nferr;
  bit exp_chk_acc;
  logic [7:0]  acc_addr, exp_addr;
  logic [15:0] acc_data, exp_data;
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic [7:0]  tx_q[$], host_q[$], exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {26'd0, rd_ack, wr_req, wr_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_err};
  endfunction

  // Register peripheral: acks after bus_lat cycles of request (never if negative).
  initial begin : bus_agent
    int wcnt;
    logic prev;
    wcnt = 0; prev = 1'b0; reg_ack = 1'b0; reg_rdata = '0;
    forever begin
      @(negedge clk);
      reg_ack = 1'b0;
      if (rst) begin
        wcnt = 0; prev = 1'b0;
      end else begin
        if ((reg_wr || reg_rd) && !prev) begin
          if (reg_wr) n_wr_acc++; else n_rd_acc++;
          req_len = 0;
        end
        if (reg_wr || reg_rd) begin
          check("bus_exclusive", 64'(reg_wr & reg_rd), 0);
          req_len++;
          if (bus_lat >= 0 && wcnt == bus_lat) begin
            reg_ack  = 1'b1;
            acc_addr = reg_addr;
            if (reg_wr) begin
              mem[reg_addr] = reg_wdata;
              acc_data      = reg_wdata;
            end else begin
              reg_rdata = mem[reg_addr];
            end
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
          reg_ack   = ($urandom_range(0, 7) == 0);
          reg_rdata = 16'($urandom);
        end
        prev = reg_wr || reg_rd;
      end
    end
  end

  // UART adapter: acks each wr_req rising edge after a random serialization delay.
  initial begin : tx_agent
    int low, dly;
    logic prev, pend;
    logic [7:0] held;
    wr_ack = 1'b0; low = 0; dly = 0; prev = 1'b0; pend = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      wr_ack = 1'b0;
      if (rst) begin
        low = 0; prev = 1'b0; pend = 1'b0;
      end else begin
        if (wr_req && !prev) begin
          check("wr_gap_ge2", 64'(low >= 2), 1);
          held = wr_data; pend = 1'b1; dly = $urandom_range(1, 4);
        end else if (wr_req) begin
          check("wr_data_stable", wr_data, held);
        end
        if (pend) begin
          dly--;
          if (dly == 0) begin
            wr_ack = 1'b1; pend = 1'b0; tx_q.push_back(held);
          end
        end
        low  = wr_req ? 0 : low + 1;
        prev = wr_req;
      end
    end
  end

  initial begin : ferr_mon
    forever begin
      @(negedge clk);
      if (!rst && frame_err) n_ferr++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    check("rd_ack_idle", 64'(rd_ack), 0);
    rd_data = b; rd_req = 1'b1;
    t = 0;
    while (!rd_ack && t < 400) begin @(negedge clk); t++; end
    check("rd_ack_rise", 64'(rd_ack), 1);
    rd_req = 1'b0; rd_data = 8'($urandom);
    t = 0;
    while (rd_ack && t < 400) begin @(negedge clk); t++; end
    check("rd_ack_fall", 64'(rd_ack), 0);
  endtask

  // Frame-level reference: kind 0=write, 1=read, 2=unknown command byte.
  task automatic model_frame(input int kind, input logic [7:0] cmd, input logic [7:0] a,
                             input logic [15:0] d, input int lat);
    bit tmo;
    logic [15:0] r;
    tmo = (lat < 0) || (lat >= BUS_TO);
    bus_lat = lat;
    host_q.delete(); exp_q.delete();
    exp_nwr = 0; exp_nrd = 0; exp_nferr = 0; exp_chk_acc = 1'b0;
    if (kind == 0) begin
      host_q.push_back(8'h57); host_q.push_back(a);
      host_q.push_back(d[15:8]); host_q.push_back(d[7:0]);
      exp_nwr = 1;
      if (tmo) exp_q.push_back(8'h21);
      else begin
        ref_mem[a] = d; exp_q.push_back(8'h4B);
        exp_chk_acc = 1'b1; exp_addr = a; exp_data = d;
      end
    end else if (kind == 1) begin
      host_q.push_back(8'h52); host_q.push_back(a);
      exp_nrd = 1;
      r = tmo ? 16'hDEAD : ref_mem[a];
      exp_q.push_back(r[15:8]); exp_q.push_back(r[7:0]);
    end else begin
      host_q.push_back(cmd);
      exp_q.push_back(8'h3F);
      exp_nferr = 1;
    end
  endtask

  task automatic do_frame(input string tag);
    int t, w0, r0, f0;
    w0 = n_wr_acc; r0 = n_rd_acc; f0 = n_ferr;
    tx_q.delete();
    foreach (host_q[i]) send_byte(host_q[i]);
    t = 0;
    while ((tx_q.size() < exp_q.size() || busy || wr_req) && t < 1000) begin
      @(negedge clk); t++;
    end
    repeat (8) @(negedge clk);
    check({tag, "_nbytes"}, tx_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < tx_q.size()) check({tag, "_byte"}, tx_q[i], exp_q[i]);
    check({tag, "_wr_acc"}, n_wr_acc - w0, exp_nwr);
    check({tag, "_rd_acc"}, n_rd_acc - r0, exp_nrd);
    check({tag, "_ferr"}, n_ferr - f0, exp_nferr);
    check({tag, "_busy"}, 64'(busy), 0);
    if (exp_chk_acc) begin
      check({tag, "_addr"}, acc_addr, exp_addr);
      check({tag, "_wdata"}, acc_data, exp_data);
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check(tag, outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_q.delete();
  endtask

  initial begin : main
    int t, f0, w0, r0, kind, lat;
    logic [7:0] cmd;
    rst = 1'b1; rd_req = 1'b0; rd_data = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
      ref_mem[i] = mem[i];
    end
    mem[8'h20] = 16'hBEEF; ref_mem[8'h20] = 16'hBEEF;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    model_frame(0, 8'h00, 8'h10, 16'h1234, 5);  do_frame("wr_basic");
    model_frame(1, 8'h00, 8'h20, 16'h0000, 5);  do_frame("rd_beef");
    model_frame(1, 8'h00, 8'h10, 16'h0000, 0);  do_frame("rd_back");
    model_frame(2, 8'h41, 8'h00, 16'h0000, 0);  do_frame("bad_cmd");

    // Inter-byte timeout after a partial write frame.
    bus_lat = 0; tx_q.delete();
    f0 = n_ferr; w0 = n_wr_acc; r0 = n_rd_acc;
    send_byte(8'h57); send_byte(8'h10);
    t = 0;
    while (!frame_err && t < 400) begin @(negedge clk); t++; end
    check("ibto_frame_err", 64'(frame_err), 1);
    check("ibto_latency", 64'(t >= TO_CYC - 2 && t <= TO_CYC + 4), 1);
    repeat (20) @(negedge clk);
    check("ibto_busy", 64'(busy), 0);
    check("ibto_no_resp", tx_q.size(), 0);
    check("ibto_no_bus", (n_wr_acc - w0) + (n_rd_acc - r0), 0);
    check("ibto_ferr_once", n_ferr - f0, 1);
    model_frame(1, 8'h00, 8'h05, 16'h0000, 2);  do_frame("rd_after_ibto");

    // Bus timeout boundaries: ack in the expiry cycle still counts.
    model_frame(1, 8'h00, 8'h30, 16'h0000, -1); do_frame("rd_bus_to");
    check("rd_bus_to_len", req_len, BUS_TO);
    model_frame(0, 8'h00, 8'h30, 16'h0001, -1); do_frame("wr_bus_to");
    check("wr_bus_to_len", req_len, BUS_TO);
    model_frame(1, 8'h00, 8'h31, 16'h0000, BUS_TO - 1); do_frame("rd_ack_at_limit");
    model_frame(1, 8'h00, 8'h32, 16'h0000, BUS_TO);     do_frame("rd_ack_past_limit");

    // Reset while a write is held on the bus.
    model_frame(0, 8'h00, 8'h40, 16'h5555, -1);
    foreach (host_q[i]) send_byte(host_q[i]);
    t = 0;
    while (!reg_wr && t < 50) begin @(negedge clk); t++; end
    check("rst_bus_reg_wr", 64'(reg_wr), 1);
    ref_mem[8'h40] = mem[8'h40];
    pulse_reset("rst_in_bus");
    model_frame(0, 8'h00, 8'h40, 16'hA5A5, 2);  do_frame("wr_after_rst1");

    // Reset while a response byte is being requested.
    model_frame(1, 8'h00, 8'h20, 16'h0000, 0);
    foreach (host_q[i]) send_byte(host_q[i]);
    t = 0;
    while (!wr_req && t < 50) begin @(negedge clk); t++; end
    check("rst_tx_wr_req", 64'(wr_req), 1);
    pulse_reset("rst_in_tx");
    model_frame(0, 8'h00, 8'h41, 16'h0F0F, 1);  do_frame("wr_after_rst2");

    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 9) < 4 ? 0 : ($urandom_range(0, 5) < 5 ? 1 : 2);
      do cmd = 8'($urandom); while (cmd == 8'h57 || cmd == 8'h52);
      lat = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 9);
      model_frame(kind, cmd, 8'($urandom_range(0, 15)), 16'($urandom), lat);
      do_frame("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Byte-level command parser that sits directly downstream of the FT232R handshake adapter.
- Consumes received bytes over its 4-phase rd_req/rd_ack interface, decodes fixed-length register read/write frames, and drives a simple internal register bus.
- Returns response bytes to the same adapter over its wr_req/wr_ack interface.
- Gives host software register access to the FPGA over the USB UART.

Parameters:
- P_TIMEOUT_CYC, 1000000: inter-byte timeout in clk cycles; a partial frame is discarded after this many idle cycles.
- P_BUS_TIMEOUT, 255: maximum cycles to wait for reg_ack before aborting a bus access.
- P_RD_ERR_DATA, 16'hDEAD: data returned for a read whose bus access timed out.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_req  in  1  adapter has a received byte available
- rd_ack  out  1  byte accepted (4-phase)
- rd_data  in  8  received byte; valid while rd_req=1
- wr_req  out  1  request adapter to transmit wr_data; adapter acts on the rising edge
- wr_ack  in  1  one-cycle pulse when the byte is fully serialized
- wr_data  out  8  byte to transmit
- reg_addr  out  8  register address
- reg_wdata  out  16  register write data
- reg_wr  out  1  write request; level, held until reg_ack or timeout
- reg_rd  out  1  read request; level, held until reg_ack or timeout
- reg_rdata  in  16  read data; sampled in the reg_ack cycle
- reg_ack  in  1  bus access complete
- busy  out  1  high whenever the main FSM is not in S_CMD
- frame_err  out  1  one-cycle pulse on unknown command or inter-byte timeout

Behaviour:
- Reset values: rd_ack=0, wr_req=0, wr_data=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, frame_err=0. FSM goes to S_CMD, counters to 0.
- Reset mid-operation aborts everything immediately. No partial bus access or response is resumed after reset.
- Receive sub-handshake:
  - Wait for rd_req=1, latch rd_data, set rd_ack=1.
  - Wait for rd_req=0, then set rd_ack=0. The byte counts as consumed on that clear.
  - Never raise rd_ack without rd_req, and never drop rd_ack before rd_req falls.
- Transmit sub-handshake:
  - Load wr_data, set wr_req=1 in the same or a later cycle; wr_data is held stable while wr_req=1.
  - On a wr_ack pulse, set wr_req=0.
  - wr_req stays low for at least 2 cycles before the next rising edge, so the adapter can detect each edge.
- Frame format (bytes MSB-first):
  - Write: 0x57 ('W'), addr, dhi, dlo. Response: 0x4B ('K'), or 0x21 ('!') on bus timeout.
  - Read: 0x52 ('R'), addr. Response: rdata[15:8], then rdata[7:0].
  - Any other first byte: respond 0x3F ('?'), pulse frame_err, return to S_CMD.
- Main FSM states: S_CMD, S_ADDR, S_DHI, S_DLO, S_BUS, S_TX0, S_TX1.
  - S_CMD -> S_ADDR on 'W'/'R'; -> S_TX0 ('?') on any other byte.
  - S_ADDR latches reg_addr; -> S_DHI for a write, -> S_BUS for a read.
  - S_DHI latches reg_wdata[15:8] -> S_DLO. S_DLO latches reg_wdata[7:0] -> S_BUS.
  - S_BUS asserts reg_wr or reg_rd on the cycle after entry. Never both at once.
  - S_BUS -> S_TX0 on reg_ack, or when the bus counter reaches P_BUS_TIMEOUT. On a read timeout, use P_RD_ERR_DATA as the response data.
  - S_TX0 sends the first response byte. Write/error responses -> S_CMD after wr_ack; reads -> S_TX1.
  - S_TX1 sends the low read byte -> S_CMD.
- Timeouts:
  - Inter-byte counter runs only in S_ADDR/S_DHI/S_DLO while waiting for rd_req, and clears on each accepted byte.
  - When it reaches P_TIMEOUT_CYC: pulse frame_err, return to S_CMD, send no response, issue no bus access.
  - A byte whose rd_req arrives in the expiry cycle is treated as a new command byte.
- Receive during response: no bytes are accepted in S_BUS/S_TX*, so rd_req stays pending and flow control backs up to the host.
- reg_ack is ignored outside S_BUS. A reg_ack in the same cycle as bus-timeout expiry counts as success.
- Counter widths are sized with $clog2 of their parameter; neither counter wraps, both saturate at terminal.

Test Plan:
- Bytes 57 10 12 34 -> one reg_wr assertion with reg_addr=0x10, reg_wdata=0x1234 held until reg_ack; then wr_data=0x4B sent once; busy returns to 0.
- Bytes 52 20, reg_ack with reg_rdata=0xBEEF after 5 cycles -> reg_rd once; response bytes 0xBE then 0xEF, each a separate wr_req rising edge with ≥2 low cycles between them.
- Byte 0x41 -> no bus access; response 0x3F; frame_err pulses once.
- Bytes 57 10, then idle > P_TIMEOUT_CYC (set to 100 in bench) -> frame_err at cycle 100; no response; next bytes 52 05 complete a normal read.
- Bytes 52 30 with reg_ack never asserted (P_BUS_TIMEOUT=16) -> reg_rd drops after 16 cycles; response 0xDE 0xAD. Same for 57 30 00 01 -> response 0x21.
- Assert rst while in S_BUS with reg_wr=1 and again while wr_req=1 -> all outputs return to reset values immediately; a following full write frame completes normally.
